timer_sequencer: RTL and testbench
==================================

// Module: timer_sequencer
// PURPOSE
//  Avalon-MM master that programs, arms and services the 16-bit-register interval timer slave.
//  Accepts a timeout request (32-bit period in clocks) from vending-machine control logic.
//  Sequences the timer register writes, confirms the counter is running, and turns each timer IRQ into a one-cycle expired pulse.
//  Clears the timer status and optionally re-arms. Sits between the vend FSM and the timer slave; sole master of that slave.
// PARAMETERS
//  CONTINUOUS  0   1: control word sets CONT bit; stays ARMED after each expiry. 0: one-shot.
//  CNT_W       16  width of saturating expiry event counter
// PORTS
//  clk            in   1      system clock; all logic on rising edge
//  reset          in   1      synchronous, active-high reset
//  start          in   1      pulse: load period and arm timer (accepted only in IDLE)
//  cancel         in   1      pulse: stop timer and return to IDLE (accepted while busy)
//  period         in   32     timeout in clocks; sampled on accepted start
//  busy           out  1      high in every state except IDLE
//  expired        out  1      one-cycle pulse per serviced timer IRQ
//  err            out  1      one-cycle pulse: period==0 on start, or running bit not set after arm
//  event_count    out  CNT_W  expiries since reset, saturates at all-ones
//  avm_address    out  3      timer register: 0 status, 1 control, 2 period_l, 3 period_h
//  avm_chipselect out  1      bus access strobe, one cycle per access
//  avm_write_n    out  1      0 = write access
//  avm_writedata  out  16     write data
//  avm_readdata   in   16     registered slave read data, valid cycle after read address
//  timer_irq      in   1      timer interrupt, level, held until status written
// BEHAVIOUR
//  Reset: state IDLE.
//    Reset output values: busy=0, expired=0, err=0, event_count=0, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0.
//    Reset mid-sequence abandons the access; the timer slave is not written.
//  Bus idle value (any cycle without access): chipselect=0, write_n=1, address=0, writedata=0.
//  Slave has no waitrequest; every access completes in its cycle. All bus outputs are registered.
//  States:
//    IDLE     start & period!=0 -> latch period, WR_PL; start & period==0 -> err pulse, stay IDLE.
//    WR_PL    write addr2 = period[15:0] -> WR_PH
//    WR_PH    write addr3 = period[31:16] -> WR_CTL
//    WR_CTL   write addr1 = 16'h0005 (START|ITO), or 16'h0007 if CONTINUOUS -> RD_STAT
//    RD_STAT  read addr0 (chipselect=1, write_n=1) -> CHK_STAT
//    CHK_STAT avm_readdata[1]==1 -> ARMED; else err pulse -> WR_STOP
//    ARMED    timer_irq -> WR_CLR; cancel -> WR_STOP
//    WR_CLR   write addr0 = 0 (clears timeout); expired=1 this cycle; event_count+1 (saturating) -> CLR_GAP
//    CLR_GAP  idle bus one cycle so the IRQ deasserts before it is re-sampled.
//             Exits: pending cancel or !CONTINUOUS -> WR_STOP; else ARMED.
//    WR_STOP  write addr1 = 16'h0008 (STOP) -> WR_SCLR
//    WR_SCLR  write addr0 = 0 -> IDLE
//  Latency: start accepted at edge N; START control write on bus at cycle N+3; ARMED at N+6.
//    IRQ seen in ARMED at cycle M -> expired at M+1.
//  Cancel during WR_PL..CHK_STAT or WR_CLR/CLR_GAP: latched into cancel_pend.
//    The in-flight sequence completes up to the next ARMED/CLR_GAP decision point, then goes to WR_STOP; no further re-arm.
//  Cancel and timer_irq in same ARMED cycle: IRQ wins (WR_CLR, expired, count), then the pending cancel goes to WR_STOP.
//  start while busy: ignored, no err. cancel in IDLE: ignored.
//  cancel_pend cleared on entry to IDLE and by reset.
// TESTING
//  1 One-shot, period=32'h0001_86A0, start:
//      writes (2,86A0),(3,0001),(1,0005); read addr0 returns bit1=1; ARMED.
//      IRQ -> expired 1 cycle, write (0,0),(1,0008),(0,0); busy=0; event_count=1.
//  2 start with period=0 -> err pulse same+1 cycle, no bus activity, busy stays 0.
//  3 CONTINUOUS=1, period=10:
//      three IRQs -> three expired pulses, event_count=3, control word 0007, state ARMED throughout.
//  4 cancel in ARMED (no IRQ) -> writes (1,0008),(0,0), expired never asserted, IDLE after 2 cycles.
//  5 cancel and timer_irq same cycle in ARMED -> expired once, count+1, then STOP sequence, IDLE.
//  6 Readback fault:
//      force avm_readdata=0 in CHK_STAT -> err pulse, STOP+clear writes, IDLE.
//    Reset asserted during WR_PH -> bus idle next cycle, busy=0, counters 0.

Source files
------------

// File: rtl/timer_sequencer.sv
// timer_sequencer
//   Avalon-MM master for the 16-bit-register interval timer. It takes a
//   32-bit timeout request from the vend FSM, writes the period and control
//   registers, and reads status back to confirm the counter is running.
//   Each timer IRQ becomes a one-cycle expired pulse, the timeout status is
//   cleared, and the timer is either re-armed (CONTINUOUS) or stopped.
//
// Parameters
//   CONTINUOUS  1: control word sets CONT, stays armed after expiry; 0: one-shot
//   CNT_W       width of the saturating expiry counter
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-high
//   start           pulse: load period and arm (IDLE only)
//   cancel          pulse: stop timer, return to IDLE (while busy)
//   period[31:0]    timeout in clocks, sampled on accepted start
//   busy            high in every state except IDLE
//   expired         one-cycle pulse per serviced IRQ
//   err             one-cycle pulse: zero period, or RUN bit not set after arm
//   event_count     expiries since reset, saturating
//   avm_*           Avalon-MM master to the timer (no waitrequest)
//   avm_readdata    registered slave read data, valid the cycle after the read
//   timer_irq       level interrupt, held until status is written
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus idle, waiting for start
// WR_PL    | writing period[15:0] to register 2
// WR_PH    | writing period[31:16] to register 3
// WR_CTL   | writing START|ITO (|CONT) to register 1
// RD_STAT  | reading status register 0
// CHK_STAT | readback visible; RUN bit decides ARMED or error stop
// ARMED    | timer running, waiting for IRQ or cancel
// WR_CLR   | clearing TO in status, expired pulse, count
// CLR_GAP  | idle bus so the IRQ deasserts before it is sampled again
// WR_STOP  | writing STOP to register 1
// WR_SCLR  | clearing status, then back to IDLE

module timer_sequencer #(
    parameter bit CONTINUOUS = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             cancel,
    input  logic [31:0]      period,
    output logic             busy,
    output logic             expired,
    output logic             err,
    output logic [CNT_W-1:0] event_count,
    output logic [2:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [15:0]      avm_writedata,
    input  logic [15:0]      avm_readdata,
    input  logic             timer_irq
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_PL,
        S_WR_PH,
        S_WR_CTL,
        S_RD_STAT,
        S_CHK_STAT,
        S_ARMED,
        S_WR_CLR,
        S_CLR_GAP,
        S_WR_STOP,
        S_WR_SCLR
    } state_t;

    localparam logic [2:0]  ADDR_STATUS  = 3'd0;
    localparam logic [2:0]  ADDR_CONTROL = 3'd1;
    localparam logic [2:0]  ADDR_PERIODL = 3'd2;
    localparam logic [2:0]  ADDR_PERIODH = 3'd3;
    localparam logic [15:0] CTL_ARM      = CONTINUOUS ? 16'h0007 : 16'h0005;
    localparam logic [15:0] CTL_STOP     = 16'h0008;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] period_hi_q;
    logic        cancel_pend;
    logic        cancel_pend_nxt;
    logic        expired_nxt;
    logic        err_nxt;
    logic        cs_nxt;
    logic        wn_nxt;
    logic [2:0]  addr_nxt;
    logic [15:0] wd_nxt;

    // Only the RUN bit of the status word matters to this sequencer.
    logic unused_rd;
    assign unused_rd = ^{avm_readdata[15:2], avm_readdata[0]};

    always_comb begin
        state_nxt       = state;
        cancel_pend_nxt = cancel_pend;
        expired_nxt     = 1'b0;
        err_nxt         = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (period != 32'd0) begin
                        state_nxt = S_WR_PL;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            S_WR_PL:    state_nxt = S_WR_PH;
            S_WR_PH:    state_nxt = S_WR_CTL;
            S_WR_CTL:   state_nxt = S_RD_STAT;
            S_RD_STAT:  state_nxt = S_CHK_STAT;
            S_CHK_STAT: begin
                if (avm_readdata[1]) begin
                    state_nxt = S_ARMED;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = S_WR_STOP;
                end
            end
            S_ARMED: begin
                // An IRQ in the same cycle as cancel is still serviced;
                // the cancel is latched below and honoured in CLR_GAP.
                if (timer_irq) begin
                    expired_nxt = 1'b1;
                    state_nxt   = S_WR_CLR;
                end else if (cancel || cancel_pend) begin
                    state_nxt = S_WR_STOP;
                end
            end
            S_WR_CLR:   state_nxt = S_CLR_GAP;
            S_CLR_GAP: begin
                if (cancel || cancel_pend || !CONTINUOUS) begin
                    state_nxt = S_WR_STOP;
                end else begin
                    state_nxt = S_ARMED;
                end
            end
            S_WR_STOP:  state_nxt = S_WR_SCLR;
            S_WR_SCLR:  state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase

        if (cancel && (state != S_IDLE)) begin
            cancel_pend_nxt = 1'b1;
        end
        if (state_nxt == S_IDLE) begin
            cancel_pend_nxt = 1'b0;
        end

        // Bus outputs are decoded from the state being entered and then
        // registered, so each access is on the bus during its own state.
        cs_nxt   = 1'b0;
        wn_nxt   = 1'b1;
        addr_nxt = 3'd0;
        wd_nxt   = 16'h0000;
        case (state_nxt)
            S_WR_PL: begin
                // Entered only from IDLE, so the live period input is the
                // value being accepted this cycle.
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_PERIODL;
                wd_nxt   = period[15:0];
            end
            S_WR_PH: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_PERIODH;
                wd_nxt   = period_hi_q;
            end
            S_WR_CTL: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_CONTROL;
                wd_nxt   = CTL_ARM;
            end
            S_RD_STAT: begin
                cs_nxt   = 1'b1;
                addr_nxt = ADDR_STATUS;
            end
            S_WR_CLR, S_WR_SCLR: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_STATUS;
            end
            S_WR_STOP: begin
                cs_nxt   = 1'b1;
                wn_nxt   = 1'b0;
                addr_nxt = ADDR_CONTROL;
                wd_nxt   = CTL_STOP;
            end
            default: begin
                cs_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            period_hi_q    <= 16'h0000;
            cancel_pend    <= 1'b0;
            busy           <= 1'b0;
            expired        <= 1'b0;
            err            <= 1'b0;
            event_count    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_address    <= 3'd0;
            avm_writedata  <= 16'h0000;
        end else begin
            state       <= state_nxt;
            cancel_pend <= cancel_pend_nxt;
            if ((state == S_IDLE) && start) begin
                period_hi_q <= period[31:16];
            end
            busy    <= (state_nxt != S_IDLE);
            expired <= expired_nxt;
            err     <= err_nxt;
            if (expired_nxt && (event_count != '1)) begin
                event_count <= event_count + CNT_W'(1);
            end
            avm_chipselect <= cs_nxt;
            avm_write_n    <= wn_nxt;
            avm_address    <= addr_nxt;
            avm_writedata  <= wd_nxt;
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
module tb_timer_sequencer;

    typedef struct {
        logic [2:0]  addr;
        logic        wn;
        logic [15:0] data;
    } acc_t;

    // mode: 0 irq, 1 cancel in ARMED, 2 cancel+irq, 3 zero period,
    //       4 bad readback, 5 cancel during arm sequence
    typedef struct {
        logic [31:0] period;
        int          mode;
        int          exp_expired;
        int          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start, cancel, busy, expired, err, cs, wn;
    logic [1:0]  irq = 2'b00;
    logic [1:0]  running = 2'b00;
    logic [1:0]  bad_rb = 2'b00;
    logic [31:0] period [2];
    logic [2:0]  addr [2];
    logic [15:0] wd [2];
    logic [15:0] rdata [2];
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int   checks = 0;
    int   errors = 0;
    int   exp_seen [2] = '{0, 0};
    int   err_seen [2] = '{0, 0};
    int   cnt_model0 = 0;
    acc_t exp_q [2][$];
    acc_t mon_e;
    vec_t vecs [7];

    always #5 clk = ~clk;

    timer_sequencer #(.CONTINUOUS(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .cancel(cancel[0]),
        .period(period[0]), .busy(busy[0]), .expired(expired[0]), .err(err[0]),
        .event_count(cnt0), .avm_address(addr[0]), .avm_chipselect(cs[0]),
        .avm_write_n(wn[0]), .avm_writedata(wd[0]), .avm_readdata(rdata[0]),
        .timer_irq(irq[0])
    );

    timer_sequencer #(.CONTINUOUS(1'b1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]), .cancel(cancel[1]),
        .period(period[1]), .busy(busy[1]), .expired(expired[1]), .err(err[1]),
        .event_count(cnt1), .avm_address(addr[1]), .avm_chipselect(cs[1]),
        .avm_write_n(wn[1]), .avm_writedata(wd[1]), .avm_readdata(rdata[1]),
        .timer_irq(irq[1])
    );

    // Timer slave model: registered status read, RUN from control writes,
    // IRQ dropped by any status write.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            rdata[d] <= (cs[d] === 1'b1 && wn[d] === 1'b1 && addr[d] == 3'd0 && !bad_rb[d])
                        ? {14'd0, running[d], irq[d]} : 16'h0000;
            if (cs[d] === 1'b1 && wn[d] === 1'b0 && addr[d] == 3'd1) begin
                if (wd[d][2]) running[d] <= 1'b1;
                if (wd[d][3]) running[d] <= 1'b0;
            end
            if (cs[d] === 1'b1 && wn[d] === 1'b0 && addr[d] == 3'd0) irq[d] = 1'b0;
        end
    end

    // Bus scoreboard and pulse counters.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (cs[d] === 1'b1) begin
                checks++;
                if (exp_q[d].size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected dut%0d: got addr=%0d wn=%0b data=%h, required no access",
                             d, addr[d], wn[d], wd[d]);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    if (addr[d] !== mon_e.addr || wn[d] !== mon_e.wn || wd[d] !== mon_e.data) begin
                        errors++;
                        $display("FAIL bus_access dut%0d: got addr=%0d wn=%0b data=%h, required addr=%0d wn=%0b data=%h",
                                 d, addr[d], wn[d], wd[d], mon_e.addr, mon_e.wn, mon_e.data);
                    end
                end
            end
            if (expired[d] === 1'b1) exp_seen[d]++;
            if (err[d] === 1'b1) err_seen[d]++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input int d, input logic [2:0] a, input logic w, input logic [15:0] v);
        acc_t e;
        e.addr = a;
        e.wn   = w;
        e.data = v;
        exp_q[d].push_back(e);
    endtask

    task automatic push_arm(input int d, input logic [31:0] p, input logic [15:0] ctl);
        push(d, 3'd2, 1'b0, p[15:0]);
        push(d, 3'd3, 1'b0, p[31:16]);
        push(d, 3'd1, 1'b0, ctl);
        push(d, 3'd0, 1'b1, 16'h0000);
    endtask

    task automatic push_stop(input int d);
        push(d, 3'd1, 1'b0, 16'h0008);
        push(d, 3'd0, 1'b0, 16'h0000);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int d, input string name);
        int n;
        n = 0;
        while (busy[d] !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, busy[d]}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int e0, r0;
        e0 = exp_seen[0];
        r0 = err_seen[0];
        period[0] = v.period;
        start[0]  = 1'b1;
        bad_rb[0] = (v.mode == 4);
        if (v.period != 32'd0) push_arm(0, v.period, 16'h0005);
        if (v.mode == 1 || v.mode == 4 || v.mode == 5) push_stop(0);
        @(negedge clk);                       // WR_PL (or IDLE with err)
        start[0] = 1'b0;
        chk("err_pulse", {31'd0, err[0]}, (v.period == 32'd0) ? 32'd1 : 32'd0);
        if (v.mode == 3) begin
            chk("zero_period_busy", {31'd0, busy[0]}, 32'd0);
            @(negedge clk);
            chk("err_one_cycle", {31'd0, err[0]}, 32'd0);
        end else begin
            @(negedge clk);                   // WR_PH
            if (v.mode == 5) cancel[0] = 1'b1;
            @(negedge clk);                   // WR_CTL
            cancel[0] = 1'b0;
            chk("ctl_write_cycle", {cs[0], wn[0], addr[0], wd[0]}, {1'b1, 1'b0, 3'd1, 16'h0005});
            cycles(3);                        // ARMED, or WR_STOP on bad readback
            if (v.mode == 4) begin
                chk("readback_err", {31'd0, err[0]}, 32'd1);
                chk("readback_stop", {cs[0], wn[0], addr[0], wd[0]}, {1'b1, 1'b0, 3'd1, 16'h0008});
            end else begin
                chk("armed_busy", {31'd0, busy[0]}, 32'd1);
                case (v.mode)
                    0: begin
                        cycles(2);
                        period[0] = 32'd0;
                        start[0]  = 1'b1;
                        @(negedge clk);
                        start[0] = 1'b0;
                        chk("start_while_busy_no_err", {31'd0, err[0]}, 32'd0);
                        irq[0] = 1'b1;
                        push(0, 3'd0, 1'b0, 16'h0000);
                        push_stop(0);
                        @(negedge clk);
                        chk("expired_m1", {31'd0, expired[0]}, 32'd1);
                        @(negedge clk);
                        chk("expired_one_cycle", {31'd0, expired[0]}, 32'd0);
                    end
                    1: begin
                        cycles(2);
                        cancel[0] = 1'b1;
                        @(negedge clk);
                        cancel[0] = 1'b0;
                        chk("cancel_stop_write", {cs[0], wn[0], addr[0], wd[0]}, {1'b1, 1'b0, 3'd1, 16'h0008});
                        cycles(2);
                        chk("cancel_idle_after_2", {31'd0, busy[0]}, 32'd0);
                    end
                    2: begin
                        cancel[0] = 1'b1;
                        irq[0]    = 1'b1;
                        push(0, 3'd0, 1'b0, 16'h0000);
                        push_stop(0);
                        @(negedge clk);
                        cancel[0] = 1'b0;
                        chk("irq_wins_expired", {31'd0, expired[0]}, 32'd1);
                    end
                    default: begin
                        @(negedge clk);
                        chk("early_cancel_stop", {cs[0], wn[0], addr[0], wd[0]}, {1'b1, 1'b0, 3'd1, 16'h0008});
                    end
                endcase
            end
        end
        wait_idle(0, "vec_idle");
        bad_rb[0] = 1'b0;
        cnt_model0 += v.exp_expired;
        chk("bus_queue_empty", exp_q[0].size(), 32'd0);
        chk("expired_count", exp_seen[0] - e0, v.exp_expired);
        chk("err_count", err_seen[0] - r0, v.exp_err);
        chk("event_count", {16'd0, cnt0}, cnt_model0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e1;
        reset     = 1'b1;
        start     = 2'b00;
        cancel    = 2'b00;
        period[0] = 32'd0;
        period[1] = 32'd0;

        vecs[0] = '{32'h0001_86A0, 0, 1, 0};
        vecs[1] = '{32'h0000_0000, 3, 0, 1};
        vecs[2] = '{32'h0000_0010, 1, 0, 0};
        vecs[3] = '{32'h1234_5678, 2, 1, 0};
        vecs[4] = '{32'hFFFF_FFFF, 4, 0, 1};
        vecs[5] = '{32'h0000_0005, 5, 0, 0};
        vecs[6] = '{32'h0000_0001, 0, 1, 0};

        cycles(3);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_expired", {31'd0, expired[0]}, 32'd0);
        chk("rst_err", {31'd0, err[0]}, 32'd0);
        chk("rst_count", {16'd0, cnt0}, 32'd0);
        chk("rst_bus", {cs[0], wn[0], addr[0], wd[0]}, {1'b0, 1'b1, 3'd0, 16'h0000});
        reset = 1'b0;
        cycles(2);

        cancel[0] = 1'b1;
        @(negedge clk);
        cancel[0] = 1'b0;
        cycles(2);
        chk("cancel_in_idle_ignored", {31'd0, busy[0]}, 32'd0);

        // Continuous instance: four IRQs against a 2-bit saturating counter.
        e1 = exp_seen[1];
        period[1] = 32'd10;
        start[1]  = 1'b1;
        push_arm(1, 32'd10, 16'h0007);
        @(negedge clk);
        start[1] = 1'b0;
        cycles(5);
        chk("cont_armed", {31'd0, busy[1]}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            irq[1] = 1'b1;
            push(1, 3'd0, 1'b0, 16'h0000);
            @(negedge clk);
            chk("cont_expired", {31'd0, expired[1]}, 32'd1);
            cycles(3);
            chk("cont_still_armed", {31'd0, busy[1]}, 32'd1);
        end
        chk("cont_count_saturated", {30'd0, cnt1}, 32'd3);
        chk("cont_expired_pulses", exp_seen[1] - e1, 32'd4);
        cancel[1] = 1'b1;
        push_stop(1);
        @(negedge clk);
        cancel[1] = 1'b0;
        wait_idle(1, "cont_cancel_idle");
        chk("cont_queue_empty", exp_q[1].size(), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            cycles(2);
        end

        // Reset during WR_PH: control word must never be written.
        period[0] = 32'h0002_0003;
        start[0]  = 1'b1;
        push(0, 3'd2, 1'b0, 16'h0003);
        push(0, 3'd3, 1'b0, 16'h0002);
        @(negedge clk);
        start[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midseq_rst_bus", {cs[0], wn[0], addr[0], wd[0]}, {1'b0, 1'b1, 3'd0, 16'h0000});
        chk("midseq_rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("midseq_rst_count0", {16'd0, cnt0}, 32'd0);
        chk("midseq_rst_count1", {30'd0, cnt1}, 32'd0);
        reset = 1'b0;
        cycles(4);
        chk("midseq_rst_stays_idle", {31'd0, busy[0]}, 32'd0);
        chk("midseq_rst_queue_empty", exp_q[0].size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
